// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types: word/line widths and the cache arbiter state encoding.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cacheline;

  typedef enum logic [1:0] {
    arb_idle    = 2'd0,
    arb_serve_i = 2'd1,
    arb_serve_d = 2'd2
  } arb_state_t;

endpackage

// File: rtl/cache_arbiter.sv
// Multiplexes I-cache and D-cache line traffic onto one physical memory port.
// Optional build macro CACHE_ARBITER_ROUND_ROBIN_EN replaces fixed D-over-I priority with round robin.
module cache_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_W = $bits(lc3b_word),
  parameter int LINE_W = $bits(lc3b_cacheline)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t state_q, state_d;
  arb_state_t both_grant;
  logic       i_req;
  logic       d_req;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

`ifdef CACHE_ARBITER_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;

  // last_grant: 0 = I-cache, 1 = D-cache; only changes when a serve state is entered.
  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == arb_idle && state_d == arb_serve_i) begin
      last_grant_d = 1'b0;
    end else if (state_q == arb_idle && state_d == arb_serve_d) begin
      last_grant_d = 1'b1;
    end else begin
      last_grant_d = last_grant_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    both_grant = last_grant_q ? arb_serve_i : arb_serve_d;
  end
`else
  always_comb begin
    both_grant = arb_serve_d;
  end
`endif

  // Outputs are pure functions of state and live inputs; unserved client sees zeros.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_pmem_resp  = 1'b0;
    i_pmem_rdata = '0;
    d_pmem_resp  = 1'b0;
    d_pmem_rdata = '0;
    case (state_q)
      arb_serve_i: begin
        pmem_read    = 1'b1;
        pmem_address = i_pmem_address;
        i_pmem_resp  = pmem_resp;
        i_pmem_rdata = pmem_rdata;
      end
      arb_serve_d: begin
        pmem_read    = d_pmem_read;
        pmem_write   = d_pmem_write;
        pmem_address = d_pmem_address;
        pmem_wdata   = d_pmem_wdata;
        d_pmem_resp  = pmem_resp;
        d_pmem_rdata = pmem_rdata;
      end
      default: begin
        pmem_read = 1'b0;
      end
    endcase
  end

  // Every serve returns through idle, which guarantees a strobe-free gap after each response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      arb_idle: begin
        if (d_req && i_req) begin
          state_d = both_grant;
        end else if (d_req) begin
          state_d = arb_serve_d;
        end else if (i_req) begin
          state_d = arb_serve_i;
        end else begin
          state_d = arb_idle;
        end
      end
      arb_serve_i, arb_serve_d: begin
        if (pmem_resp) begin
          state_d = arb_idle;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = arb_idle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= arb_idle;
    end else begin
      state_q <= state_d;
    end
  end

endmodule
